// File: rtl/mod107_residue_accum.sv
// Sequential modulo-MOD accumulator: sums NUM_CHUNKS partial residues, one per handshake.
// Optional macro RES_CHECK_EN: range-check and correct each residue, raise sticky err.
module mod107_residue_accum #(
    parameter int MOD        = 107,
    parameter int RES_W      = 7,
    parameter int NUM_CHUNKS = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic             busy,
    output logic             err
);
    localparam int CNT_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [RES_W:0] MOD_C = (RES_W + 1)'(MOD);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0] out_res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [RES_W-1:0] res_c;
    logic [RES_W:0]   sum_c, red_c;
    logic             accept_c;

    assign accept_c = in_valid & in_ready_q;

`ifdef RES_CHECK_EN
    logic oor_c;
    logic err_q;
    assign oor_c = ({1'b0, in_res} >= MOD_C);
    assign res_c = oor_c ? RES_W'({1'b0, in_res} - MOD_C) : in_res;
    assign err   = err_q;
`else
    assign res_c = in_res;
    assign err   = 1'b0;
`endif

    // Both operands are below MOD, so one conditional subtract fully reduces.
    assign sum_c = {1'b0, acc_q} + {1'b0, res_c};
    assign red_c = sum_c - MOD_C;
    assign acc_d = (sum_c >= MOD_C) ? red_c[RES_W-1:0] : sum_c[RES_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_res_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RES_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= ACC;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
`ifdef RES_CHECK_EN
                    err_q      <= 1'b0;
`endif
                end
                ACC: if (accept_c) begin
                    acc_q <= acc_d;
`ifdef RES_CHECK_EN
                    if (oor_c) err_q <= 1'b1;
`endif
                    if (cnt_q == LAST_C) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        out_res_q   <= acc_d;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign busy      = busy_q;
endmodule
